rca_nibble_sched: RTL and testbench
===================================

Name: rca_nibble_sched

Overview:
- Scheduler that time-shares one external 4-bit ripple-carry adder between two requesters.
- Each request is a pair of WIDTH-bit operands plus a carry-in. The block arbitrates round-robin between requests, feeds the adder one nibble per cycle (LSB nibble first), chains the carry through a register, and assembles the wide result.
- Sits between client logic and the shared 4-bit adder instance; the adder itself stays purely combinational.

Parameters:
- NIBBLES, 4, number of 4-bit passes per operation; WIDTH = 4*NIBBLES (default 16). Legal range 2..16.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has an operation pending
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_a  input  WIDTH  requester 0 operand A
- req0_b  input  WIDTH  requester 0 operand B
- req0_cin  input  1  requester 0 carry-in
- req1_valid, req1_ready, req1_a, req1_b, req1_cin  same directions/widths as requester 0, for requester 1
- add_a  output  4  nibble of A to the shared adder
- add_b  output  4  nibble of B to the shared adder
- add_cin  output  1  carry into the shared adder
- add_sum  input  4  sum from the shared adder (combinational)
- add_cout  input  1  carry out from the shared adder
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer accepts result
- rsp_sum  output  WIDTH  wide sum
- rsp_cout  output  1  final carry out
- rsp_ovf  output  1  two's-complement overflow
- rsp_id  output  1  requester that owns the result (0/1)

Behaviour:
- States: IDLE, RUN, RESP. Reset (rst=1 at a clock edge):
  - state=IDLE, rr_ptr=0, cnt=0, carry_reg=0;
  - rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_ovf=0, rsp_id=0;
  - req*_ready=0, add_a/add_b/add_cin=0.
- IDLE:
  - Grant rule (combinational): if exactly one reqN_valid is high, grant that requester. If both are high, grant requester rr_ptr.
  - reqN_ready=1 only for the granted requester, only in IDLE, and only in that cycle. Handshake completes when valid&&ready.
  - On accept: latch A, B and id; set carry_reg=cin and cnt=0; go to RUN.
- RUN, cycle k (cnt=k, 0..NIBBLES-1):
  - Drive add_a=A[4k+3:4k], add_b=B[4k+3:4k], add_cin=carry_reg.
  - At the edge: sum_reg[4k+3:4k]<=add_sum, carry_reg<=add_cout, cnt<=cnt+1.
  - At k=NIBBLES-1, go to RESP.
- add_a/add_b/add_cin are 0 outside RUN.
- RESP:
  - rsp_valid=1; rsp_sum=sum_reg, rsp_cout=carry_reg; rsp_ovf=(A[MSB]==B'[MSB])&&(sum_reg[MSB]!=A[MSB]), where B' is the effective B operand; rsp_id=latched id.
  - Outputs are held stable while rsp_ready=0 (unbounded backpressure).
  - On rsp_valid&&rsp_ready: go to IDLE, rr_ptr<=~rsp_id, rsp_valid<=0.
- Latency: accept edge T. rsp_valid rises after edge T+NIBBLES. Minimum spacing between accepts is NIBBLES+2 cycles. No accept is possible in RUN or RESP; both readies stay 0.
- Request inputs are sampled only at the accept edge. Later changes to req*_a/b/cin do not affect the operation in flight.
- Reset mid-RUN or mid-RESP: the operation is discarded, no response is produced, and the block returns to IDLE with rr_ptr=0.
- Arithmetic is unsigned modulo 2^WIDTH. The carry wraps out into rsp_cout only.

Optional Feature:
- Macro RCA_NIBBLE_SCHED_SUB_EN.
- Defined:
  - Adds input ports req0_sub and req1_sub, latched at accept.
  - When sub=1, B' = ~B, and the initial carry_reg is 1 (reqN_cin ignored), so rsp_sum = A-B. rsp_cout=1 means no borrow. rsp_ovf uses B'.
- Undefined: the ports do not exist and B'=B always.

Test Plan:
- NIBBLES=4, req0: A=0x1234, B=0x4321, cin=0 -> rsp_sum=0x5555, cout=0, ovf=0, id=0; rsp_valid rises 4 cycles after the accept edge; add_a sequence 4,3,2,1.
- req1: A=0xFFFF, B=0x0001, cin=0 -> rsp_sum=0x0000, cout=1, ovf=0. Then A=0x7FFF, B=0x0001 -> rsp_sum=0x8000, ovf=1, cout=0.
- Both valid continuously, with distinct operands -> accept order 0,1,0,1 and rsp_id alternating; neither requester is granted twice in a row.
- rsp_ready held low for 10 cycles in RESP -> rsp_* stable, both readies 0, no new accept; the first cycle after rsp_ready=1 returns to IDLE.
- Assert rst during RUN at cnt=2 -> no rsp_valid, next operation result correct, rr_ptr=0 (req0 wins a tie).
- With RCA_NIBBLE_SCHED_SUB_EN defined, sub=1: A=0x0005, B=0x0007 -> rsp_sum=0xFFFE, cout=0. Then A=0x8000, B=0x0001 -> rsp_sum=0x7FFF, ovf=1.

Source files
------------

// File: rtl/rca_nibble_sched.sv
// Round-robin scheduler sharing one external 4-bit ripple-carry adder between two requesters.
// Optional subtract support (A - B per requester) is enabled by defining RCA_NIBBLE_SCHED_SUB_EN.
module rca_nibble_sched #(
  parameter int NIBBLES = 4,
  localparam int WIDTH = 4 * NIBBLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
`ifdef RCA_NIBBLE_SCHED_SUB_EN
  input  logic             req0_sub,
  input  logic             req1_sub,
`endif
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_ovf,
  output logic             rsp_id
);

  localparam int CW = $clog2(NIBBLES);
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

  state_t           r_state, w_next;
  logic             r_rrPtr, r_id, r_carry, r_aMsb, r_bMsb;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a, r_b, r_sum;

  logic             w_grant0, w_grant1, w_accept, w_sub, w_cin;
  logic [WIDTH-1:0] w_a, w_b, w_bEff;

  // Arbitration and operand selection; B is inverted here for subtraction so the datapath only adds.
  always_comb begin
    w_grant0 = req0_valid && (!req1_valid || !r_rrPtr);
    w_grant1 = req1_valid && (!req0_valid || r_rrPtr);
    w_accept = (r_state == IDLE) && !rst && (w_grant0 || w_grant1);
    w_a      = w_grant1 ? req1_a : req0_a;
    w_b      = w_grant1 ? req1_b : req0_b;
`ifdef RCA_NIBBLE_SCHED_SUB_EN
    w_sub    = w_grant1 ? req1_sub : req0_sub;
`else
    w_sub    = 1'b0;
`endif
    w_bEff   = w_sub ? ~w_b : w_b;
    w_cin    = w_sub ? 1'b1 : (w_grant1 ? req1_cin : req0_cin);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = RUN;
      RUN:     if (r_cnt == LAST) w_next = RESP;
      RESP:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Operands shift right one nibble per pass; the sum fills from the top so nibble 0 lands at the LSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rrPtr <= 1'b0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_id    <= 1'b0;
      r_aMsb  <= 1'b0;
      r_bMsb  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_a     <= w_a;
          r_b     <= w_bEff;
          r_aMsb  <= w_a[WIDTH-1];
          r_bMsb  <= w_bEff[WIDTH-1];
          r_id    <= w_grant1;
          r_carry <= w_cin;
          r_cnt   <= '0;
        end
        RUN: begin
          r_sum   <= {add_sum, r_sum[WIDTH-1:4]};
          r_carry <= add_cout;
          r_cnt   <= r_cnt + 1'b1;
          r_a     <= r_a >> 4;
          r_b     <= r_b >> 4;
        end
        RESP: if (rsp_ready) r_rrPtr <= ~r_id;
        default: ;
      endcase
    end
  end

  assign req0_ready = w_accept && w_grant0;
  assign req1_ready = w_accept && w_grant1;
  assign add_a      = (r_state == RUN) ? r_a[3:0] : 4'h0;
  assign add_b      = (r_state == RUN) ? r_b[3:0] : 4'h0;
  assign add_cin    = (r_state == RUN) && r_carry;
  assign rsp_valid  = (r_state == RESP);
  assign rsp_sum    = (r_state == RESP) ? r_sum : '0;
  assign rsp_cout   = (r_state == RESP) && r_carry;
  assign rsp_ovf    = (r_state == RESP) && (r_aMsb == r_bMsb) && (r_sum[WIDTH-1] != r_aMsb);
  assign rsp_id     = (r_state == RESP) && r_id;

endmodule

// File: tb/tb_rca_nibble_sched.sv
// Bench for rca_nibble_sched: arithmetic reference model checked every cycle plus directed literal checks.
// Define RCA_NIBBLE_SCHED_SUB_EN to also exercise the subtract path.
module tb_rca_nibble_sched;

  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic req0_cin = 1'b0, req1_cin = 1'b0;
`ifdef RCA_NIBBLE_SCHED_SUB_EN
  logic req0_sub = 1'b0, req1_sub = 1'b0;
`endif
  logic [3:0] add_a, add_b, add_sum;
  logic add_cin, add_cout;
  logic rsp_valid, rsp_ready = 1'b1;
  logic [W-1:0] rsp_sum;
  logic rsp_cout, rsp_ovf, rsp_id;

  rca_nibble_sched #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
`ifdef RCA_NIBBLE_SCHED_SUB_EN
    .req0_sub(req0_sub), .req1_sub(req1_sub),
`endif
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .rsp_ovf(rsp_ovf), .rsp_id(rsp_id)
  );

  // The shared external adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int mPhase = 0, mK = 0;
  logic mRr = 1'b0, mId = 1'b0, mCin = 1'b0, mCout = 1'b0, mOvf = 1'b0;
  logic [W-1:0] mA = '0, mB = '0, mSum = '0;

  int acceptLog[$], respIds[$];
  logic [3:0] addLog[$];
  int respCount = 0, acceptCyc = -100, firstValidCyc = 0;
  logic prevValid = 1'b0, lastCout = 1'b0, lastOvf = 1'b0, lastId = 1'b0;
  logic [W-1:0] lastSum = '0;

  task automatic checkOutput(input string name, input longint unsigned actual, input longint unsigned expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Reference model: phase 0 idle, 1 running nibble mK, 2 holding a response.
  always @(negedge clk) begin : compare
    logic g0, g1, eSub;
    logic [W-1:0] eB;
    logic [W:0] full;
    longint unsigned la, lb, mask;
    int sh;
    if (rst) begin
      checkOutput("rstReady0", req0_ready, 0);
      checkOutput("rstReady1", req1_ready, 0);
      mPhase = 0; mK = 0; mRr = 1'b0; prevValid = 1'b0;
    end else begin
      g0 = (mPhase == 0) && req0_valid && (!req1_valid || !mRr);
      g1 = (mPhase == 0) && req1_valid && (!req0_valid || mRr);
      checkOutput("ready0", req0_ready, g0);
      checkOutput("ready1", req1_ready, g1);
      if (mPhase == 1) begin
        sh = 4 * mK; la = mA; lb = mB;
        mask = (64'd1 << sh) - 64'd1;
        checkOutput("addA", add_a, (la >> sh) & 64'hF);
        checkOutput("addB", add_b, (lb >> sh) & 64'hF);
        checkOutput("addCin", add_cin, ((la & mask) + (lb & mask) + mCin) >> sh);
      end else begin
        checkOutput("addAIdle", add_a, 0);
        checkOutput("addBIdle", add_b, 0);
        checkOutput("addCinIdle", add_cin, 0);
      end
      checkOutput("rspValid", rsp_valid, mPhase == 2);
      if (mPhase == 2) begin
        checkOutput("rspSum", rsp_sum, mSum);
        checkOutput("rspCout", rsp_cout, mCout);
        checkOutput("rspOvf", rsp_ovf, mOvf);
        checkOutput("rspId", rsp_id, mId);
      end
      if (cyc > acceptCyc && cyc <= acceptCyc + NIBBLES) addLog.push_back(add_a);
      if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
        acceptLog.push_back(req1_valid && req1_ready ? 1 : 0);
        acceptCyc = cyc;
        addLog.delete();
      end
      if (rsp_valid && !prevValid) firstValidCyc = cyc;
      prevValid = rsp_valid;
      if (rsp_valid && rsp_ready) begin
        respCount++;
        lastSum = rsp_sum; lastCout = rsp_cout; lastOvf = rsp_ovf; lastId = rsp_id;
        respIds.push_back(int'(rsp_id));
      end
      case (mPhase)
        0: if (g0 || g1) begin
`ifdef RCA_NIBBLE_SCHED_SUB_EN
          eSub = g1 ? req1_sub : req0_sub;
`else
          eSub = 1'b0;
`endif
          mA = g1 ? req1_a : req0_a;
          eB = g1 ? req1_b : req0_b;
          mB = eSub ? ~eB : eB;
          mCin = eSub ? 1'b1 : (g1 ? req1_cin : req0_cin);
          mId = g1;
          full = {1'b0, mA} + {1'b0, mB} + {{W{1'b0}}, mCin};
          mSum = full[W-1:0];
          mCout = full[W];
          mOvf = (mA[W-1] == mB[W-1]) && (mSum[W-1] != mA[W-1]);
          mPhase = 1; mK = 0;
        end
        1: begin
          mK++;
          if (mK == NIBBLES) mPhase = 2;
        end
        default: if (rsp_ready) begin
          mPhase = 0;
          mRr = !mId;
        end
      endcase
    end
  end

  task automatic applyStimulus(input bit port, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    bit done = 0;
    if (port) begin req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1'b1; end
    else      begin req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1'b1; end
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (port ? req1_ready : req0_ready) done = 1;
    end
    checkOutput("acceptTimeout", done, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic waitResponse(input int target);
    for (int i = 0; i < 60 && respCount < target; i++) begin
      @(posedge clk); #1;
    end
    checkOutput("respTimeout", respCount >= target, 1);
  endtask

  task automatic doReset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin : stim
    int base, rbase, target;
    bit seen;
    logic [3:0] expSeq[4];
    expSeq = '{4'h4, 4'h3, 4'h2, 4'h1};

    repeat (3) @(posedge clk);
    #1 req0_valid = 1'b1;
    @(negedge clk);
    checkOutput("resetRspValid", rsp_valid, 0);
    checkOutput("resetRspSum", rsp_sum, 0);
    checkOutput("resetAddA", add_a, 0);
    checkOutput("resetReady0", req0_ready, 0);
    @(posedge clk); #1;
    req0_valid = 1'b0; rst = 1'b0;

    // Basic add, latency and nibble order.
    target = respCount + 1;
    applyStimulus(0, 16'h1234, 16'h4321, 1'b0);
    waitResponse(target);
    checkOutput("t1Sum", lastSum, 16'h5555);
    checkOutput("t1Cout", lastCout, 0);
    checkOutput("t1Ovf", lastOvf, 0);
    checkOutput("t1Id", lastId, 0);
    checkOutput("t1Latency", firstValidCyc - acceptCyc, 5);
    checkOutput("t1AddLen", addLog.size(), 4);
    for (int i = 0; i < addLog.size() && i < 4; i++) checkOutput("t1AddSeq", addLog[i], expSeq[i]);

    // Wrap-around carry, signed overflow, carry-in.
    target = respCount + 1;
    applyStimulus(1, 16'hFFFF, 16'h0001, 1'b0);
    waitResponse(target);
    checkOutput("t2Sum", lastSum, 16'h0000);
    checkOutput("t2Cout", lastCout, 1);
    checkOutput("t2Ovf", lastOvf, 0);
    checkOutput("t2Id", lastId, 1);
    target = respCount + 1;
    applyStimulus(1, 16'h7FFF, 16'h0001, 1'b0);
    waitResponse(target);
    checkOutput("t3Sum", lastSum, 16'h8000);
    checkOutput("t3Cout", lastCout, 0);
    checkOutput("t3Ovf", lastOvf, 1);
    target = respCount + 1;
    applyStimulus(0, 16'h00FF, 16'h0000, 1'b1);
    waitResponse(target);
    checkOutput("t4SumCin", lastSum, 16'h0100);

    // Backpressure: response held, no accepts while both requesters wait.
    rsp_ready = 1'b0;
    applyStimulus(0, 16'h0A0A, 16'h0505, 1'b0);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = rsp_valid;
    end
    checkOutput("bpValid", seen, 1);
    @(posedge clk); #1;
    req0_a = 16'h1111; req0_b = 16'h0101; req0_cin = 1'b0;
    req1_a = 16'h2222; req1_b = 16'h0202; req1_cin = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    base = acceptLog.size();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("bpSum", rsp_sum, 16'h0F0F);
      checkOutput("bpHoldValid", rsp_valid, 1);
      checkOutput("bpReady0", req0_ready, 0);
      checkOutput("bpReady1", req1_ready, 0);
    end
    @(posedge clk); #1;
    checkOutput("bpNoAccept", acceptLog.size() - base, 0);
    target = respCount + 2;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("bpNextGrant1", req1_ready, 1);
    checkOutput("bpNextGrant0", req0_ready, 0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    waitResponse(target);
    checkOutput("bpLastSum", lastSum, 16'h2424);
    checkOutput("bpLastId", lastId, 1);

    // Round robin with both requesters continuously valid.
    doReset();
    base = acceptLog.size();
    rbase = respIds.size();
    target = respCount + 4;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 100 && acceptLog.size() < base + 4; i++) begin
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checkOutput("rrAcceptCount", acceptLog.size() - base, 4);
    waitResponse(target);
    for (int i = 0; i < 4 && base + i < acceptLog.size(); i++) checkOutput("rrOrder", acceptLog[base + i], i % 2);
    for (int i = 0; i < 4 && rbase + i < respIds.size(); i++) checkOutput("rrRspId", respIds[rbase + i], i % 2);

    // Reset in the middle of an operation.
    base = respCount;
    applyStimulus(1, 16'h0F0F, 16'h0101, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("rstNoRsp", respCount - base, 0);
    req0_a = 16'h0003; req0_b = 16'h0004;
    req1_a = 16'h0010; req1_b = 16'h0020;
    req0_valid = 1'b1; req1_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = req0_ready || req1_ready;
    end
    checkOutput("rstTieSeen", seen, 1);
    checkOutput("rstTieReady0", req0_ready, 1);
    checkOutput("rstTieReady1", req1_ready, 0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    waitResponse(base + 1);
    checkOutput("rstNextSum", lastSum, 16'h0007);
    checkOutput("rstNextId", lastId, 0);

`ifdef RCA_NIBBLE_SCHED_SUB_EN
    // Subtraction.
    req0_sub = 1'b1;
    target = respCount + 1;
    applyStimulus(0, 16'h0005, 16'h0007, 1'b0);
    waitResponse(target);
    checkOutput("subSum", lastSum, 16'hFFFE);
    checkOutput("subCout", lastCout, 0);
    target = respCount + 1;
    applyStimulus(0, 16'h8000, 16'h0001, 1'b0);
    waitResponse(target);
    checkOutput("subOvfSum", lastSum, 16'h7FFF);
    checkOutput("subOvf", lastOvf, 1);
    checkOutput("subOvfCout", lastCout, 1);
    req0_sub = 1'b0;
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
